fan_tach_capture: RTL

FAN_TACH_CAPTURE -- requirements
Module: fan_tach_capture

---
 rtl/fan_tach_capture.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fan_tach_capture.sv
// Fan tachometer period capture: synchronize and debounce tach_in, then
// count prescaled ticks between accepted falling edges, flagging a stall.
module fan_tach_capture #(
  parameter int unsigned PRESCALE = 100,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned PERIOD_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                tach_in,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stall
);

  localparam int unsigned PRE_W = $clog2(PRESCALE);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, MEAS} state_t;

  logic                r_sync1;
  logic                r_sync2;
  logic                r_filt;
  logic                r_filt_d;
  logic                r_evt;
  logic [3:0]          r_dcnt;
  logic [PRE_W-1:0]    r_pre;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic                r_valid;
  logic                r_stall;
  state_t              r_state;
  state_t              w_state_nxt;

  logic                w_tick;
  logic                w_fall;
  logic                w_capture;
  logic                w_stall_set;
  logic                w_clear;
  logic                w_cnt_sat;
  logic [PERIOD_W-1:0] w_cap_val;

  // Synchronizer keeps sampling even while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= tach_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_dcnt   <= '0;
      r_evt    <= 1'b0;
    end else if (ena) begin
      r_filt_d <= r_filt;
      r_evt    <= w_fall;
      if (r_sync2 != r_filt) begin
        if (r_dcnt == 4'(DEBOUNCE - 1)) begin
          r_filt <= r_sync2;
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + 4'd1;
        end
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  assign w_fall    = r_filt_d & ~r_filt;
  assign w_tick    = ena && (r_pre == PRE_W'(PRESCALE - 1));
  assign w_cnt_sat = (r_cnt == CNT_MAX);
  // A tick landing in the capture cycle is folded into the captured value.
  assign w_cap_val = (w_tick && !w_cnt_sat) ? r_cnt + 1'b1 : r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (ena) begin
      if (w_clear) begin
        r_pre <= '0;
        r_cnt <= '0;
      end else begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick && !w_cnt_sat) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_stall_set = 1'b0;
    w_clear     = 1'b0;
    if (ena) begin
      case (r_state)
        IDLE: begin
          if (r_evt) begin
            w_clear     = 1'b1;
            w_state_nxt = MEAS;
          end
        end
        MEAS: begin
          if (r_evt) begin
            w_capture = 1'b1;
            w_clear   = 1'b1;
          end else if (w_cnt_sat) begin
            w_stall_set = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_valid  <= 1'b0;
      r_stall  <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_period <= w_cap_val;
        r_stall  <= 1'b0;
      end else if (w_stall_set) begin
        r_period <= CNT_MAX;
        r_stall  <= 1'b1;
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign stall        = r_stall;

endmodule
